// File: rtl/flow_pkg.sv
// flow_pkg: shared constants, address type and popcount helper for the flow pipe sequencer
package flow_pkg;
    localparam int FLOW_DEPTH_DEF = 3;
    localparam int FLOW_AW_DEF = 2;
    typedef logic [FLOW_AW_DEF-1:0] flow_addr_t;
    function automatic int unsigned popcount(input logic [31:0] x);
        int unsigned n = 0;
        for (int i = 0; i < 32; i++) n += {31'b0, x[i]};
        return n;
    endfunction
endpackage

// File: rtl/flow_pipe_sequencer_if.sv
// flow_pipe_sequencer_if: valid/ready, flush, stage-load and capture-RAM write signals
// Stall_cnt exists only when STALL_CNT_EN is defined.
interface flow_pipe_sequencer_if #(
    parameter int DEPTH = 3,
    parameter int AW = 2,
    parameter int CW = 2
);
    logic Valid_i, Ready_o, Flush_i, Valid_o, Ready_i, Wr_en;
    logic [DEPTH-1:0] LD;
    logic [AW-1:0] Wr_addr;
    logic [CW-1:0] Count;
`ifdef STALL_CNT_EN
    logic [15:0] Stall_cnt;
`endif
    modport master (
        output Valid_i, Flush_i, Ready_i,
        input Ready_o, Valid_o, LD, Wr_en, Wr_addr, Count
`ifdef STALL_CNT_EN
        , Stall_cnt
`endif
    );
    modport slave (
        input Valid_i, Flush_i, Ready_i,
        output Ready_o, Valid_o, LD, Wr_en, Wr_addr, Count
`ifdef STALL_CNT_EN
        , Stall_cnt
`endif
    );
endinterface

// File: rtl/flow_wr_addr_gen.sv
// flow_wr_addr_gen: wrapping capture-RAM write address, advanced once per enabled cycle
module flow_wr_addr_gen #(
    parameter int AW = 2
) (
    input  logic          CLK,
    input  logic          RESET_n,
    input  logic          en,
    output logic [AW-1:0] addr
);
    always_ff @(posedge CLK) begin
        if (!RESET_n) addr <= '0;
        else if (en) addr <= addr + 1'b1;
    end
endmodule

// File: rtl/flow_pipe_sequencer.sv
// flow_pipe_sequencer: bubble-collapsing stage-valid tracker and load-enable generator for a DFF chain
// Define STALL_CNT_EN to add the saturating Stall_cnt output.
module flow_pipe_sequencer
    import flow_pkg::*;
#(
    parameter int DEPTH = FLOW_DEPTH_DEF,
    parameter int AW = FLOW_AW_DEF,
    parameter int CW = 2
) (
    input logic CLK,
    input logic RESET_n,
    flow_pipe_sequencer_if.slave bus
);
    logic [DEPTH-1:0] v, acc, ld, out;
    logic [AW-1:0] wr_addr;
    logic live;
    assign live = RESET_n & !bus.Flush_i;
    // acc[k]: stage k can take a new item this cycle (empty, or everything ahead moves)
    assign acc[DEPTH-1] = !v[DEPTH-1] | bus.Ready_i;
    assign out[DEPTH-1] = bus.Ready_i;
    assign ld[0] = bus.Valid_i & acc[0] & live;
    genvar k;
    for (k = 0; k < DEPTH-1; k++) begin : g_chain
        assign acc[k] = !v[k] | acc[k+1];
        assign out[k] = acc[k+1];
        assign ld[k+1] = v[k] & acc[k+1] & live;
    end
    always_ff @(posedge CLK) begin
        v <= live ? (ld | (v & ~out)) : '0;
    end
    assign bus.Ready_o = acc[0] & live;
    assign bus.LD = ld;
    assign bus.Valid_o = v[DEPTH-1];
    assign bus.Wr_en = v[DEPTH-1] & bus.Ready_i & RESET_n;
    assign bus.Count = CW'(popcount(32'(v)));
    assign bus.Wr_addr = wr_addr;
    flow_wr_addr_gen #(.AW(AW)) u_wr_addr (
        .CLK(CLK),
        .RESET_n(RESET_n),
        .en(bus.Wr_en),
        .addr(wr_addr)
    );
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
    always_ff @(posedge CLK) begin
        if (!RESET_n) stall_cnt <= '0;
        else if (bus.Valid_o & !bus.Ready_i & ~&stall_cnt) stall_cnt <= stall_cnt + 16'd1;
    end
    assign bus.Stall_cnt = stall_cnt;
`endif
endmodule
